// File: rtl/echo_pipe_pkg.sv
// Message layout for the Echo indication pipe, shared by the sending and receiving ends.
package echo_pipe_pkg;

  localparam logic [31:0] TAG_HEARD  = 32'd1;
  localparam int          ECHO_MSG_W = 96;
  localparam int          FIELD_W    = 32;
  localparam int          TAG_LSB    = 0;
  localparam int          METH_LSB   = 32;
  localparam int          V_LSB      = 64;

  // Member order puts v in the top word and tag in the bottom word.
  typedef struct packed {
    logic [FIELD_W-1:0] v;
    logic [FIELD_W-1:0] meth;
    logic [FIELD_W-1:0] tag;
  } echo_msg_t;

  function automatic echo_msg_t pack_heard(input logic [FIELD_W-1:0] meth,
                                           input logic [FIELD_W-1:0] v);
    echo_msg_t m;
    m.v    = v;
    m.meth = meth;
    m.tag  = TAG_HEARD;
    return m;
  endfunction

endpackage

// File: rtl/echo_msg_fifo.sv
// Small synchronous FIFO holding buffered heard() calls; head is registered storage, with no bypass.
module echo_msg_fifo #(
  parameter  int DEPTH  = 2,
  parameter  int DATA_W = 64,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LAST_IDX = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

  logic [PTR_W:0]    wptr_q, wptr_d;
  logic [PTR_W:0]    rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] p);
    return (p == LAST_IDX) ? '0 : p + ONE;
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (enq) begin
      mem_d[wptr_q[PTR_W-1:0]] = enq_data;
      wptr_d = ptr_inc(wptr_q);
    end
    if (deq) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rptr_q[PTR_W-1:0]];
  assign count = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL_CNT);

endmodule

// File: rtl/echo_indication_output.sv
// Transmit side of the Echo indication channel: buffers heard() calls and emits tagged pipe messages.
module echo_indication_output
  import echo_pipe_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  indication_heard__ENA,
  input  logic [FIELD_W-1:0]    indication_heard_meth,
  input  logic [FIELD_W-1:0]    indication_heard_v,
  output logic                  indication_heard__RDY,
  output logic                  pipe_enq__ENA,
  output logic [ECHO_MSG_W-1:0] pipe_enq_v,
  input  logic                  pipe_enq__RDY,
  input  logic                  rule_enable,
  output logic                  rule_ready,
  output logic [31:0]           sent_count
);

  logic                   fifo_full, fifo_empty;
  logic [2*FIELD_W-1:0]   fifo_head;
  logic [PTR_W:0]         fifo_count;
  logic                   heard_fire, send_fire;
  logic [31:0]            sent_count_q, sent_count_d;
  echo_msg_t              msg;

  assign indication_heard__RDY = !fifo_full;
  assign heard_fire            = indication_heard__ENA && !fifo_full;
  assign rule_ready            = !fifo_empty && pipe_enq__RDY;
  assign send_fire             = rule_enable && rule_ready;
  assign pipe_enq__ENA         = send_fire;

  echo_msg_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2*FIELD_W)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .enq      (heard_fire),
    .enq_data ({indication_heard_v, indication_heard_meth}),
    .deq      (send_fire),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  // Stale storage behind an empty FIFO must never leak onto the pipe.
  always_comb begin
    msg          = '0;
    sent_count_d = sent_count_q;
    if (!fifo_empty) msg = pack_heard(fifo_head[FIELD_W-1:0], fifo_head[2*FIELD_W-1:FIELD_W]);
    if (send_fire)   sent_count_d = sent_count_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) sent_count_q <= '0;
    else       sent_count_q <= sent_count_d;
  end

  assign pipe_enq_v = msg;
  assign sent_count = sent_count_q;

  a_enq_not_empty: assert property (@(posedge CLK) disable iff (!nRST) pipe_enq__ENA |-> !fifo_empty);
  a_heard_not_full: assert property (@(posedge CLK) disable iff (!nRST) heard_fire |-> !fifo_full);
  a_count_bound: assert property (@(posedge CLK) disable iff (!nRST) fifo_count <= (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_echo_indication_output.sv
// Directed bench: vector table for the main flow plus hand sequences for async reset and counter wrap.
module tb_echo_indication_output;
  import echo_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_ena = 1'b0;
  logic [31:0] h_meth = '0;
  logic [31:0] h_v = '0;
  logic        h_rdy;
  logic        p_ena;
  logic [95:0] p_v;
  logic        p_rdy = 1'b0;
  logic        r_en = 1'b0;
  logic        r_rdy;
  logic [31:0] s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  echo_indication_output #(.DEPTH(2)) dut (
    .CLK                   (clk),
    .nRST                  (rst_n),
    .indication_heard__ENA (h_ena),
    .indication_heard_meth (h_meth),
    .indication_heard_v    (h_v),
    .indication_heard__RDY (h_rdy),
    .pipe_enq__ENA         (p_ena),
    .pipe_enq_v            (p_v),
    .pipe_enq__RDY         (p_rdy),
    .rule_enable           (r_en),
    .rule_ready            (r_rdy),
    .sent_count            (s_cnt)
  );

  typedef struct {
    logic        h_ena;
    logic [31:0] meth;
    logic [31:0] v;
    logic        p_rdy;
    logic        r_en;
    logic        e_hrdy;
    logic        e_rr;
    logic        e_ena;
    logic [95:0] e_v;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] m(input logic [31:0] meth, input logic [31:0] v);
    return {v, meth, 32'd1};
  endfunction

  function automatic vec_t mk(input logic he, input logic [31:0] meth, input logic [31:0] v,
                              input logic pr, input logic re, input logic ehr, input logic err,
                              input logic eena, input logic [95:0] ev, input logic [31:0] ec);
    vec_t t;
    t.h_ena = he; t.meth = meth; t.v = v; t.p_rdy = pr; t.r_en = re;
    t.e_hrdy = ehr; t.e_rr = err; t.e_ena = eena; t.e_v = ev; t.e_cnt = ec;
    return t;
  endfunction

  task automatic check_outs(input string tag, input logic ehr, input logic err, input logic eena,
                            input logic [95:0] ev, input logic [31:0] ec);
    chk({tag, ".heard_rdy"},  {95'd0, h_rdy}, {95'd0, ehr});
    chk({tag, ".rule_ready"}, {95'd0, r_rdy}, {95'd0, err});
    chk({tag, ".enq_ena"},    {95'd0, p_ena}, {95'd0, eena});
    chk({tag, ".enq_v"},      p_v, ev);
    chk({tag, ".sent_count"}, {64'd0, s_cnt}, {64'd0, ec});
  endtask

  initial begin
    // single message
    vecs[0]  = mk(1, 32'h1, 32'hDEAD_BEEF, 1, 1,  1, 0, 0, '0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 1,                  1, 1, 1, m(32'h1, 32'hDEAD_BEEF), 0);
    vecs[2]  = mk(0, 0, 0, 1, 1,                  1, 0, 0, '0, 1);
    // fill under backpressure, third call ignored, then drain
    vecs[3]  = mk(1, 32'hA0, 32'd10, 0, 1,        1, 0, 0, '0, 1);
    vecs[4]  = mk(1, 32'hA1, 32'd11, 0, 1,        1, 0, 0, m(32'hA0, 32'd10), 1);
    vecs[5]  = mk(1, 32'hA2, 32'd12, 0, 1,        0, 0, 0, m(32'hA0, 32'd10), 1);
    vecs[6]  = mk(0, 0, 0, 1, 1,                  0, 1, 1, m(32'hA0, 32'd10), 1);
    vecs[7]  = mk(0, 0, 0, 1, 1,                  1, 1, 1, m(32'hA1, 32'd11), 2);
    vecs[8]  = mk(0, 0, 0, 1, 1,                  1, 0, 0, '0, 3);
    // simultaneous enq/deq at count 1, then rule_enable held low
    vecs[9]  = mk(1, 32'hB0, 32'd7, 1, 0,         1, 0, 0, '0, 3);
    vecs[10] = mk(1, 32'hB1, 32'd5, 1, 1,         1, 1, 1, m(32'hB0, 32'd7), 3);
    vecs[11] = mk(0, 0, 0, 1, 0,                  1, 1, 0, m(32'hB1, 32'd5), 4);
    vecs[12] = mk(0, 0, 0, 1, 0,                  1, 1, 0, m(32'hB1, 32'd5), 4);
    vecs[13] = mk(0, 0, 0, 1, 1,                  1, 1, 1, m(32'hB1, 32'd5), 4);
    vecs[14] = mk(0, 0, 0, 1, 1,                  1, 0, 0, '0, 5);

    // reset held, then idle after release
    repeat (2) @(negedge clk);
    #1 check_outs("in_reset", 1, 0, 0, '0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_outs("idle", 1, 0, 0, '0, 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      h_ena = vecs[i].h_ena; h_meth = vecs[i].meth; h_v = vecs[i].v;
      p_rdy = vecs[i].p_rdy; r_en = vecs[i].r_en;
      #1 check_outs($sformatf("vec%0d", i), vecs[i].e_hrdy, vecs[i].e_rr, vecs[i].e_ena,
                    vecs[i].e_v, vecs[i].e_cnt);
    end

    // async reset with two entries buffered
    @(negedge clk);
    h_ena = 1; h_meth = 32'hC0; h_v = 32'd20; p_rdy = 0; r_en = 0;
    @(negedge clk);
    h_meth = 32'hC1; h_v = 32'd21;
    @(negedge clk);
    h_ena = 0;
    #1 check_outs("two_buffered", 0, 0, 0, m(32'hC0, 32'd20), 5);
    p_rdy = 1; r_en = 1;
    #1 chk("pre_reset.enq_ena", {95'd0, p_ena}, 96'd1);
    rst_n = 1'b0;
    #1 check_outs("async_reset", 1, 0, 0, '0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_outs("post_release", 1, 0, 0, '0, 0);
    @(negedge clk);
    #1 check_outs("post_release2", 1, 0, 0, '0, 0);

    // sent_count wrap
    @(negedge clk);
    h_ena = 1; h_meth = 32'hD0; h_v = 32'd30; r_en = 0; p_rdy = 1;
    @(negedge clk);
    h_ena = 0;
    force dut.sent_count_d = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.sent_count_d;
    r_en = 1;
    #1 check_outs("pre_wrap", 1, 1, 1, m(32'hD0, 32'd30), 32'hFFFF_FFFF);
    @(negedge clk);
    r_en = 0;
    #1 check_outs("wrap", 1, 0, 0, '0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_indication_output.md
Name: echo_indication_output

Overview:
- Transmit side of the Echo indication channel.
- Accepts indication$heard(meth, v) method calls from the design and buffers them in a small FIFO.
- Serialises each call into the 96-bit tagged pipe message (tag 1 = heard) and issues it through pipe$enq under control of the scheduler's rule_enable / rule_ready pair.
- Its output is exactly the stream the Echo indication receiver consumes on its pipe$enq input.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- PTR_W, 1, log2(DEPTH); derived, not overridden independently.

Ports:
- CLK  input  1  clock; all state on posedge.
- nRST  input  1  asynchronous active-low reset.
- indication$heard__ENA  input  1  caller invokes heard this cycle.
- indication$heard_meth  input  32  heard argument meth.
- indication$heard_v  input  32  heard argument v.
- indication$heard__RDY  output  1  heard may be invoked.
- pipe$enq__ENA  output  1  message is enqueued to the pipe this cycle.
- pipe$enq_v  output  96  packed message.
- pipe$enq__RDY  input  1  pipe can accept.
- rule_enable  input  1  scheduler enable for send_rule (bit 0).
- rule_ready  output  1  send_rule ready (bit 0).
- sent_count  output  32  messages sent since reset.

Behaviour:
- Message packing:
  - pipe$enq_v[31:0] = tag, constant 1 (TAG_HEARD).
  - pipe$enq_v[63:32] = meth.
  - pipe$enq_v[95:64] = v.
  - When the FIFO is empty, pipe$enq_v = 96'h0.
- Storage: DEPTH x 64-bit entries {v, meth}.
  - Read pointer, write pointer and occupancy count are (PTR_W+1)-bit registers.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- heard handshake:
  - indication$heard__RDY = !full.
  - heard_fire = ENA && RDY; on fire, write {v, meth} at wptr and increment wptr.
  - ENA while RDY is low is ignored: no state change.
- send_rule:
  - rule_ready = !empty && pipe$enq__RDY.
  - send_fire = rule_enable && rule_ready.
  - pipe$enq__ENA = send_fire, combinational, same cycle.
  - On send_fire: increment rptr and sent_count.
- Count update:
  - heard_fire only: count + 1.
  - send_fire only: count - 1.
  - Both in the same cycle: count unchanged, both pointers advance.
  - Simultaneous is legal only when not full, because RDY gates heard.
  - No write-when-full bypass.
- Latency: no empty-path bypass. A message accepted in cycle N is first presentable on pipe$enq_v, with rule_ready possibly high, in cycle N+1.
- Ordering: strict FIFO; messages leave in acceptance order.
- sent_count: 32-bit, wraps from 32'hFFFF_FFFF to 0.
- Backpressure: while pipe$enq__RDY = 0, rule_ready = 0. Head entry and pipe$enq_v stay stable; the FIFO keeps accepting until full.
- Reset (nRST low, asynchronous assert): pointers, count, sent_count and storage all cleared.
  - Resulting outputs: indication$heard__RDY = 1, pipe$enq__ENA = 0, pipe$enq_v = 0, rule_ready = 0, sent_count = 0.
  - Reset mid-operation discards buffered messages; no partial message is emitted.
  - Release is synchronised externally; the block performs no action in the release cycle other than normal operation.
- Invariants (assert in sim):
  - count <= DEPTH.
  - pipe$enq__ENA implies !empty.
  - heard_fire implies !full.

Decomposition:
- Shared package echo_pipe_pkg:
  - TAG_HEARD = 32'd1.
  - ECHO_MSG_W = 96.
  - Field offsets: TAG_LSB = 0, METH_LSB = 32, V_LSB = 64, FIELD_W = 32.
  - Message struct/typedef {v, meth, tag}.
  - Shared with the receiving block so both ends agree on layout.
- One sub-module: echo_msg_fifo, a DEPTH-parameterised synchronous FIFO with enq/deq/full/empty and head output.
  - Top level holds packing, rule logic and sent_count.

Test Plan:
- Reset then idle:
  - Expected: heard__RDY = 1, rule_ready = 0, pipe$enq_v = 0, sent_count = 0.
- Single message: heard(meth = 32'h1, v = 32'hDEAD_BEEF) at cycle 0; rule_enable and pipe$enq__RDY held high.
  - Expected: pipe$enq__ENA only at cycle 1, with pipe$enq_v = {32'hDEAD_BEEF, 32'h1, 32'h1}; sent_count = 1.
- Fill and backpressure: pipe$enq__RDY = 0, heard called 3 times with v = 10, 11, 12.
  - Expected: first two accepted, heard__RDY = 0 after the second, third ignored.
  - Then raise RDY: v = 10 then v = 11 emitted on consecutive cycles; heard__RDY returns to 1 after the first send.
- Simultaneous enq/deq with count = 1: heard(v = 5) and send fire in the same cycle.
  - Expected: count stays 1, the old head is sent, v = 5 becomes the head next cycle.
- rule_enable = 0 with a message buffered and pipe$enq__RDY = 1.
  - Expected: rule_ready = 1, pipe$enq__ENA = 0, nothing dequeued.
- Async reset asserted mid-cycle with 2 entries buffered.
  - Expected: immediately heard__RDY = 1, rule_ready = 0, pipe$enq_v = 0, sent_count = 0; no stale message after release.
- Wrap check: sent_count preloaded via force to 32'hFFFF_FFFF, then one send.
  - Expected: sent_count = 0.
